// File: rtl/mem_access_ctrl.sv
// Single-port RAM access controller: arbitrates instruction fetch and data
// requests (data wins), with write protection for addresses below WR_BASE.
module mem_access_ctrl #(
  parameter logic [3:0] WR_BASE = 4'd13
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       fetch_req,
  input  logic [3:0] fetch_addr,
  output logic       fetch_ack,
  output logic [7:0] fetch_data,
  input  logic       data_req,
  input  logic       data_we,
  input  logic [3:0] data_addr,
  input  logic [7:0] data_wdata,
  output logic       data_ack,
  output logic [7:0] data_rdata,
  output logic       data_fault,
  output logic       prot_violation,
  output logic       busy,
  output logic [3:0] ram_address,
  output logic [7:0] ram_data_in,
  output logic       ram_write_enable,
  input  logic [7:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        grant_s;
  logic        grant_data_s;
  logic        in_access_s;
  logic        wr_ok_s;
  logic        wr_refused_s;
  logic        port_data_r;
  logic        we_r;
  logic [3:0]  mar_r;
  logic [7:0]  mdr_r;
  logic [7:0]  fetch_data_r;
  logic [7:0]  data_rdata_r;
  logic        fetch_ack_r;
  logic        data_ack_r;
  logic        data_fault_r;
  logic        prot_violation_r;
  logic        busy_r;

  // Next-state and grant decode; data port has priority over fetch.
  always_comb begin
    state_nxt_s  = state_r;
    grant_s      = 1'b0;
    grant_data_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_req) begin
          grant_s      = 1'b1;
          grant_data_s = 1'b1;
          state_nxt_s  = ACCESS;
        end else if (fetch_req) begin
          grant_s      = 1'b1;
          state_nxt_s  = ACCESS;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Write strobe depends only on state and latched we/MAR, so reset kills it at once.
  assign in_access_s      = (state_r == ACCESS);
  assign wr_ok_s          = in_access_s && we_r && (mar_r >= WR_BASE);
  assign wr_refused_s     = in_access_s && we_r && (mar_r < WR_BASE);
  assign ram_write_enable = wr_ok_s;

  // State register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch on grant: port, MAR, MDR and write flag are frozen for the transaction.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      port_data_r <= 1'b0;
      we_r        <= 1'b0;
      mar_r       <= 4'd0;
      mdr_r       <= 8'd0;
    end else if (grant_s) begin
      port_data_r <= grant_data_s;
      we_r        <= grant_data_s & data_we;
      mar_r       <= grant_data_s ? data_addr : fetch_addr;
      mdr_r       <= data_wdata;
    end else begin
      port_data_r <= port_data_r;
      we_r        <= we_r;
      mar_r       <= mar_r;
      mdr_r       <= mdr_r;
    end
  end

  // Read capture at the end of ACCESS into the granted port's data register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fetch_data_r <= 8'd0;
      data_rdata_r <= 8'd0;
    end else if (in_access_s && !we_r) begin
      if (port_data_r) begin
        data_rdata_r <= ram_data_out;
      end else begin
        fetch_data_r <= ram_data_out;
      end
    end else begin
      fetch_data_r <= fetch_data_r;
      data_rdata_r <= data_rdata_r;
    end
  end

  // Handshake/status flags, registered so they are high exactly during RESP.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fetch_ack_r      <= 1'b0;
      data_ack_r       <= 1'b0;
      data_fault_r     <= 1'b0;
      prot_violation_r <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      fetch_ack_r      <= in_access_s & ~port_data_r;
      data_ack_r       <= in_access_s & port_data_r;
      data_fault_r     <= wr_refused_s;
      prot_violation_r <= prot_violation_r | wr_refused_s;
      busy_r           <= (state_nxt_s != IDLE);
    end
  end

  assign fetch_ack      = fetch_ack_r;
  assign fetch_data     = fetch_data_r;
  assign data_ack       = data_ack_r;
  assign data_rdata     = data_rdata_r;
  assign data_fault     = data_fault_r;
  assign prot_violation = prot_violation_r;
  assign busy           = busy_r;
  assign ram_address    = mar_r;
  assign ram_data_in    = mdr_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, corner-case sequences
// and randomized transactions against a transaction-level RAM/protection model.
module tb_mem_access_ctrl;

  localparam logic [3:0] WR_BASE_TB = 4'd13;

  logic       clk;
  logic       sys_rst_n;
  logic       fetch_req;
  logic [3:0] fetch_addr;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic       data_req;
  logic       data_we;
  logic [3:0] data_addr;
  logic [7:0] data_wdata;
  logic       data_ack;
  logic [7:0] data_rdata;
  logic       data_fault;
  logic       prot_violation;
  logic       busy;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic [7:0] ram_data_out;

  mem_access_ctrl #(.WR_BASE(WR_BASE_TB)) dut (
    .clk              (clk),
    .sys_rst_n        (sys_rst_n),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ack        (fetch_ack),
    .fetch_data       (fetch_data),
    .data_req         (data_req),
    .data_we          (data_we),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_ack         (data_ack),
    .data_rdata       (data_rdata),
    .data_fault       (data_fault),
    .prot_violation   (prot_violation),
    .busy             (busy),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM attached to the controller; preloaded with 0x1C + address on the first edge.
  logic [7:0] mem [16];
  bit         mem_ready;
  assign ram_data_out = mem[ram_address];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h1C + 8'(i);
      mem_ready <= 1'b1;
    end else if (ram_write_enable) begin
      mem[ram_address] <= ram_data_in;
    end
  end

  // Reference model: memory image, sticky protection flag, last read bytes per port.
  logic [7:0] ref_ram [16];
  bit         ref_prot;
  logic [7:0] ref_frd;
  logic [7:0] ref_drd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_acks"}, {fetch_ack, data_ack, data_fault}, 32'd0);
    chk({tag, "_prot_busy"}, {prot_violation, busy}, 32'd0);
    chk({tag, "_rdata"}, {fetch_data, data_rdata}, 32'd0);
    chk({tag, "_ram_if"}, {ram_address, ram_data_in, ram_write_enable}, 32'd0);
  endtask

  // One transaction; request set on a negedge, outputs sampled on later negedges.
  task automatic txn(input bit is_d, input bit we, input logic [3:0] a, input logic [7:0] wd,
                     input bit drop_early, output logic [7:0] rd, output bit flt);
    int cyc;
    int wep;
    bit got;
    bit exp_flt;
    @(negedge clk);
    chk("idle_busy", busy, 32'd0);
    chk("idle_acks", {fetch_ack, data_ack}, 32'd0);
    if (is_d) begin
      data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd;
    end else begin
      fetch_req = 1'b1; fetch_addr = a;
    end
    cyc = 1; wep = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        chk("busy_access", busy, 32'd1);
        data_addr = 4'($urandom); data_wdata = 8'($urandom); fetch_addr = 4'($urandom);
        data_we = 1'($urandom);
        if (drop_early) begin
          data_req = 1'b0; fetch_req = 1'b0;
        end
      end
      if (ram_write_enable) begin
        wep++;
        chk("we_addr", ram_address, a);
        chk("we_data", ram_data_in, wd);
      end
      if (fetch_ack || data_ack) got = 1'b1;
    end
    chk("ack_cycle", cyc, 32'd3);
    chk("ack_port", {fetch_ack, data_ack}, is_d ? 32'd1 : 32'd2);
    chk("busy_resp", busy, 32'd1);
    exp_flt = is_d && we && (a < WR_BASE_TB);
    if (is_d && we) begin
      if (exp_flt) ref_prot = 1'b1;
      else ref_ram[a] = wd;
    end else if (is_d) begin
      ref_drd = ref_ram[a];
    end else begin
      ref_frd = ref_ram[a];
    end
    chk("wr_pulses", wep, (is_d && we && !exp_flt) ? 32'd1 : 32'd0);
    chk("fault", data_fault, exp_flt);
    chk("prot", prot_violation, ref_prot);
    chk("fetch_data", fetch_data, ref_frd);
    chk("data_rdata", data_rdata, ref_drd);
    chk("ram_content", mem[a], ref_ram[a]);
    rd  = is_d ? data_rdata : fetch_data;
    flt = data_fault;
    fetch_req = 1'b0;
    data_req  = 1'b0;
  endtask

  typedef struct {
    bit         is_d;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    bit         exp_flt;
  } vec_t;

  vec_t       vt [12];
  logic [7:0] rd;
  bit         flt;
  int         cyc, d_c, f_c, overlap, k;
  int         ack_c [4];

  initial begin
    vt[0]  = '{1'b0, 1'b0, 4'd2,  8'h00, 8'h1E, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 4'd14, 8'hA5, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 4'd14, 8'h00, 8'hA5, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 4'd5,  8'hFF, 8'h00, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 4'd5,  8'h00, 8'h21, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 4'd5,  8'h00, 8'h21, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 4'd15, 8'h3C, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 4'd15, 8'h00, 8'h3C, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 4'd12, 8'h77, 8'h00, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 4'd12, 8'h00, 8'h28, 1'b0};
    vt[10] = '{1'b1, 1'b1, 4'd13, 8'h5A, 8'h00, 1'b0};
    vt[11] = '{1'b1, 1'b0, 4'd13, 8'h00, 8'h5A, 1'b0};

    for (int i = 0; i < 16; i++) ref_ram[i] = 8'h1C + 8'(i);
    ref_prot = 1'b0; ref_frd = 8'd0; ref_drd = 8'd0;

    sys_rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 4'd0; data_req = 1'b0;
    data_we = 1'b0; data_addr = 4'd0; data_wdata = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    sys_rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      txn(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wd, 1'b0, rd, flt);
      if (!(vt[i].is_d && vt[i].we)) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_fault", i), flt, vt[i].exp_flt);
    end

    // Contention: both requests on the same edge; data first, fetch next.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 4'd3; data_req = 1'b1; data_we = 1'b0; data_addr = 4'd7;
    cyc = 1; d_c = 0; f_c = 0; overlap = 0;
    while (f_c == 0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (fetch_ack && data_ack) overlap++;
      if (data_ack) begin
        d_c = cyc; data_req = 1'b0;
        chk("cont_drd", data_rdata, ref_ram[7]);
      end
      if (fetch_ack) begin
        f_c = cyc; fetch_req = 1'b0;
        chk("cont_frd", fetch_data, ref_ram[3]);
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    chk("cont_data_cyc", d_c, 32'd3);
    chk("cont_fetch_cyc", f_c, 32'd6);
    chk("cont_overlap", overlap, 32'd0);
    ref_drd = ref_ram[7]; ref_frd = ref_ram[3];

    // Back-to-back fetches with fetch_req held and the PC stepping 0..3.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 4'd0;
    cyc = 1; k = 0;
    while (k < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (fetch_ack) begin
        ack_c[k] = cyc;
        chk($sformatf("b2b_data%0d", k), fetch_data, ref_ram[k]);
        k++;
        fetch_addr = 4'(k);
        if (k == 4) fetch_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
    chk("b2b_count", k, 32'd4);
    for (int i = 0; i < k; i++) chk($sformatf("b2b_cyc%0d", i), ack_c[i], 32'(3 * (i + 1)));
    ref_frd = ref_ram[3];

    // Reset during ACCESS of an allowed write to the lowest writable address.
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b1; data_addr = 4'd13; data_wdata = 8'hC3;
    @(negedge clk);
    chk("midwr_we_before", {ram_write_enable, ram_address}, {1'b1, 4'd13});
    #2 sys_rst_n = 1'b0;
    #1 chk_reset_outputs("midwr");
    data_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs("midwr_hold");
    end
    chk("midwr_ram13", mem[13], ref_ram[13]);
    sys_rst_n = 1'b1;
    ref_prot = 1'b0; ref_frd = 8'd0; ref_drd = 8'd0;

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
          ($urandom_range(0, 3) == 0), rd, flt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WR_BASE, default 4'd13: lowest RAM address accepted for writes; addresses below it are code memory and read-only.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fetch_req  input  1  instruction-fetch read request; held high until fetch_ack.
REQ-005 fetch_addr  input  4  fetch address (program counter value).
REQ-006 fetch_ack  output  1  one-cycle pulse: fetch complete, fetch_data valid.
REQ-007 fetch_data  output  8  fetched byte; holds until next fetch completes.
REQ-008 data_req  input  1  data-port request; held high until data_ack.
REQ-009 data_we  input  1  1 = write, 0 = read; sampled with data_req.
REQ-010 data_addr  input  4  data-port address.
REQ-011 data_wdata  input  8  write data.
REQ-012 data_ack  output  1  one-cycle pulse: data access complete.
REQ-013 data_rdata  output  8  read byte; holds until next data read completes.
REQ-014 data_fault  output  1  pulses with data_ack when a write was refused.
REQ-015 prot_violation  output  1  sticky flag, set on any refused write, cleared only by reset.
REQ-016 busy  output  1  high whenever the FSM is not IDLE.
REQ-017 ram_address  output  4  RAM address, driven from the registered MAR.
REQ-018 ram_data_in  output  8  RAM write data, driven from the registered MDR.
REQ-019 ram_write_enable  output  1  RAM write strobe.
REQ-020 ram_data_out  input  8  RAM combinational read data for ram_address.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP, and SHALL always follow IDLE -> ACCESS -> RESP -> IDLE, giving 3 cycles per transaction.
REQ-022 In IDLE, the block SHALL grant data_req when it is high, and SHALL grant fetch_req only when data_req is low (data priority).
REQ-023 On a grant, the block SHALL latch the following and go to ACCESS: port ID, address into MAR, data_we (forced 0 for fetch), and data_wdata into MDR.
REQ-024 In ACCESS with a read, the block SHALL capture ram_data_out at the clock edge into fetch_data or data_rdata according to the granted port.
REQ-025 In ACCESS with a write and MAR >= WR_BASE, ram_write_enable SHALL be 1 for exactly that cycle.
REQ-026 ram_write_enable SHALL be decoded combinationally from state, the latched we and MAR only, and SHALL never be asserted outside ACCESS.
REQ-027 In ACCESS with a write and MAR < WR_BASE, the block SHALL suppress the write, record the fault, and set prot_violation.
REQ-028 In RESP, the block SHALL assert the granted port's ack for exactly one cycle, and SHALL assert data_fault in that same cycle if the write was refused.
REQ-029 The block SHALL sample requests again only in IDLE, so a request held high after its ack is served again from the next IDLE.
REQ-030 If a request drops before its ack, the block SHALL still complete the transaction and pulse the ack.
REQ-031 The block SHALL ignore address and data changes after the grant; the latched values are used.
REQ-032 When both requests are pending, the block SHALL serve data first and serve fetch in the next transaction (fetch latency 6 cycles).
REQ-033 Address arithmetic SHALL be a 4-bit comparison only, with no wrap handling required; address 15 is valid and writable.

Reset
REQ-034 While sys_rst_n is low, the block SHALL hold: state = IDLE; MAR, MDR, fetch_data and data_rdata = 0; all acks, data_fault, prot_violation and busy = 0.
REQ-035 Reset asserted in ACCESS SHALL force ram_write_enable low immediately and abort the transaction with no ack issued.
REQ-036 After reset release, the block SHALL accept its first request on the first rising edge at which sys_rst_n is high.

Verification
REQ-037 Fetch read: RAM[2] = 8'h1E, fetch_addr = 2, fetch_req held -> fetch_ack pulses on the 3rd cycle with fetch_data = 8'h1E, and busy is high for 2 cycles.
REQ-038 Allowed write: data_we = 1, addr = 14, wdata = 8'hA5 -> ram_write_enable is high for one cycle with ram_address = 14 and ram_data_in = 8'hA5; a later read of addr 14 returns 8'hA5.
REQ-039 Protected write: data_we = 1, addr = 5, wdata = 8'hFF -> ram_write_enable stays 0, data_ack and data_fault pulse together, prot_violation stays 1 until reset, and RAM[5] is unchanged.
REQ-040 Contention: fetch_req and data_req rise on the same edge -> data_ack arrives at cycle 3 and fetch_ack at cycle 6, with no overlap of the acks.
REQ-041 Reset mid-write: sys_rst_n is dropped during ACCESS of a write to addr 13 -> ram_write_enable falls at once, RAM[13] is unchanged, no ack occurs, and all outputs take their reset values.
REQ-042 Back-to-back: fetch_req is held for 4 consecutive transactions with the address incrementing 0..3 -> 4 fetch_ack pulses occur exactly 3 cycles apart with the correct bytes.
